// File: rtl/vlc_tx_ctrl_if.sv
// Byte handshake between a requester and vlc_tx_ctrl.
// master drives tx_data/tx_valid and reads tx_ready; slave is the reverse.
interface vlc_tx_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/vlc_tx_ctrl.sv
// OOK serial transmitter for a VLC LED: start(0), 8 data LSB first,
// optional even parity, stop(1); each bit lasts DIV = CLK_HZ/BAUD clocks.
// Ports: clk_in, rst_n (async, active-low), tx (byte handshake, slave),
//   led_out (registered line, 1 = idle), busy, baud_tick (bit boundary).
// Build option: define VLC_TX_PARITY_EN to add the parity bit.
module vlc_tx_ctrl #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic          clk_in,
  input  logic          rst_n,
  vlc_tx_ctrl_if.slave  tx,
  output logic          led_out,
  output logic          busy,
  output logic          baud_tick
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef VLC_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          led_q, led_d;
  logic          tick;
`ifdef VLC_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      led_q   <= 1'b1;
`ifdef VLC_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      led_q   <= led_d;
`ifdef VLC_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // led_d is the level of the state being entered, so the line
  // stays registered and changes exactly on the bit boundary edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    led_d   = led_q;
`ifdef VLC_TX_PARITY_EN
    par_d   = par_q;
`endif
    tick = (state_q != S_IDLE) && (cnt_q == LAST);

    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        led_d = 1'b1;
        if (tx.tx_valid) begin
          sh_d    = tx.tx_data;
          idx_d   = '0;
          led_d   = 1'b0;
          state_d = S_START;
`ifdef VLC_TX_PARITY_EN
          par_d   = ^tx.tx_data;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          idx_d   = '0;
          led_d   = sh_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d = sh_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef VLC_TX_PARITY_EN
            led_d   = par_q;
            state_d = S_PARITY;
`else
            led_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            led_d = sh_q[1];
          end
        end
      end
`ifdef VLC_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          led_d   = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          led_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        led_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx.tx_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign baud_tick   = tick;
  assign led_out     = led_q;

endmodule

// File: tb/tb_vlc_tx_ctrl.sv
// Directed bench for vlc_tx_ctrl at a small divider (DIV = 5).
// Checks every cycle of every frame against hand-built bit patterns.
module tb_vlc_tx_ctrl;

  localparam int CLK_HZ = 50;
  localparam int BAUD   = 10;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef VLC_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  logic led_out;
  logic busy;
  logic baud_tick;

  int n_cmp = 0;
  int n_err = 0;

  vlc_tx_ctrl_if tx_if ();

  vlc_tx_ctrl #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .tx        (tx_if.slave),
    .led_out   (led_out),
    .busy      (busy),
    .baud_tick (baud_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  // Sends d; after acceptance drives tx_valid/tx_data to nv/nd,
  // then checks every cycle of the frame and the idle cycle after.
  task automatic send(
    input logic [7:0] d,
    input logic       nv,
    input logic [7:0] nd
  );
    logic [10:0] bits;
    int ticks;
    int w;
    w = 0;
    while (tx_if.tx_ready !== 1'b1 && w < 100) begin
      @(negedge clk_in);
      w++;
    end
    chk($sformatf("rdy_wait %02h", d), tx_if.tx_ready, 1);
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef VLC_TX_PARITY_EN
    bits[9]   = ^d;
`endif
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    tx_if.tx_valid = nv;
    tx_if.tx_data  = nd;
    ticks = 0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("led %02h b%0d c%0d", d, b, c),
            led_out, bits[b]);
        chk($sformatf("busy %02h b%0d", d, b), busy, 1);
        chk($sformatf("rdy %02h b%0d", d, b),
            tx_if.tx_ready, 0);
        chk($sformatf("tick %02h b%0d c%0d", d, b, c),
            baud_tick, (c == DIV - 1));
        if (baud_tick === 1'b1) ticks++;
        @(negedge clk_in);
      end
    end
    chk($sformatf("nticks %02h", d), ticks, NB);
    chk($sformatf("idle_led %02h", d), led_out, 1);
    chk($sformatf("idle_rdy %02h", d), tx_if.tx_ready, 1);
    chk($sformatf("idle_busy %02h", d), busy, 0);
    chk($sformatf("idle_tick %02h", d), baud_tick, 0);
  endtask

  initial begin
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;

    // reset with no clock edge in between
    #1 rst_n = 1'b0;
    #1;
    chk("rst_led", led_out, 1);
    chk("rst_rdy", tx_if.tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", baud_tick, 0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // accepted on the first edge after release
    send(8'hA5, 1'b0, 8'h00);

    // back-to-back with tx_valid held
    send(8'h3C, 1'b1, 8'hFF);
    send(8'hFF, 1'b0, 8'h00);

    // new request during a frame is ignored
    send(8'h55, 1'b1, 8'h00);
    send(8'h00, 1'b0, 8'h00);

    // reset in the middle of DATA
    tx_if.tx_data  = 8'hF0;
    tx_if.tx_valid = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    tx_if.tx_valid = 1'b0;
    repeat (3 * DIV + 2) @(negedge clk_in);
    chk("mid_led", led_out, 0);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", led_out, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", tx_if.tx_ready, 1);
    chk("arst_tick", baud_tick, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk($sformatf("hold_led %0d", i), led_out, 1);
    end
    rst_n = 1'b1;
    send(8'h81, 1'b0, 8'h00);

    // parity 1 then 0 when enabled
    send(8'h07, 1'b0, 8'h00);
    send(8'h03, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
